// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its buttons, counter datapath and display.
// The controller takes the slave side; the board or bench drives the master side.
interface stopwatch_ctrl_if #(
    parameter int TW = 20
);
    logic          btn_ss;
    logic          btn_lr;
    logic [TW-1:0] time_in;
    logic          cnt_en;
    logic          cnt_clr;
    logic [TW-1:0] time_out;
    logic [1:0]    state;
    logic          lap_led;

    modport master (
        output btn_ss, btn_lr, time_in,
        input  cnt_en, cnt_clr, time_out, state, lap_led
    );

    modport slave (
        input  btn_ss, btn_lr, time_in,
        output cnt_en, cnt_clr, time_out, state, lap_led
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces two pushbuttons, runs the
// IDLE/RUN/LAP/STOP state machine and freezes the displayed time while in LAP.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int TW        = 20
) (
    input  logic            clk_sys,
    input  logic            rstn,
    stopwatch_ctrl_if.slave bus
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_e;

    // Bit 0 is the start/stop button, bit 1 is the lap/reset button.
    logic [1:0]          btn_raw;
    logic [1:0]          s1_q, s1_d;
    logic [1:0]          s2_q, s2_d;
    logic [1:0]          stable_q, stable_d;
    logic [1:0]          prev_q, prev_d;
    logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;

    state_e              state_q, state_d;
    logic                cnt_en_q, cnt_en_d;
    logic                cnt_clr_q, cnt_clr_d;
    logic [TW-1:0]       snap_q, snap_d;

    logic                press_ss;
    logic                press_lr;

    assign btn_raw = {bus.btn_lr, bus.btn_ss};

    // Debounce: the stable level only follows s2 after DB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        s1_d     = btn_raw;
        s2_d     = s1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = s2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
        end
    end

    assign press_ss = stable_q[0] & ~prev_q[0];
    assign press_lr = stable_q[1] & ~prev_q[1];

    // State register together with the registered outputs and the button pipeline.
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            prev_q    <= '0;
            // NOTE: the debounce counters and snapshot are plain flops, not RAM, so they take the async reset.
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            snap_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            prev_q    <= prev_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            snap_q    <= snap_d;
        end
    end

    // Next state: a start/stop press always takes priority over a simultaneous lap/reset press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_ss) state_d = RUN;
            end
            RUN: begin
                if (press_ss)      state_d = STOP;
                else if (press_lr) state_d = LAP;
            end
            LAP: begin
                if (press_ss)      state_d = STOP;
                else if (press_lr) state_d = RUN;
            end
            STOP: begin
                if (press_ss)      state_d = RUN;
                else if (press_lr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: enable follows the next state so it flips on the same edge as the state.
    always_comb begin
        cnt_en_d  = (state_d == RUN) || (state_d == LAP);
        cnt_clr_d = press_lr && !press_ss && ((state_q == IDLE) || (state_q == STOP));
        snap_d    = ((state_q == RUN) && (state_d == LAP)) ? bus.time_in : snap_q;
    end

    assign bus.cnt_en   = cnt_en_q;
    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.state    = state_q;
    assign bus.lap_led  = (state_q == LAP);
    assign bus.time_out = (state_q == LAP) ? snap_q : bus.time_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl with a short debounce window; expected
// observations are queued as stimulus is applied and compared after each edge.
module tb_stopwatch_ctrl;

    localparam int DB       = 4;
    localparam int TW       = 20;
    localparam int PRESS_AT = DB + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAP  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    typedef struct packed {
        logic [1:0]    st;
        logic          en;
        logic          clr;
        logic          led;
        logic [TW-1:0] t;
    } obs_t;

    logic clk_sys = 1'b0;
    logic rstn    = 1'b0;

    stopwatch_ctrl_if #(.TW(TW)) bus ();

    stopwatch_ctrl #(.DB_CYCLES(DB), .TW(TW)) dut (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    obs_t sb[$];
    obs_t got, want;
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t mk(logic [1:0] st, logic en, logic clr, logic led, logic [TW-1:0] t);
        obs_t e;
        e.st = st; e.en = en; e.clr = clr; e.led = led; e.t = t;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t e;
        e.st = bus.state; e.en = bus.cnt_en; e.clr = bus.cnt_clr;
        e.led = bus.lap_led; e.t = bus.time_out;
        return e;
    endfunction

    function automatic string fmt(obs_t e);
        return $sformatf("state=%0d cnt_en=%b cnt_clr=%b lap_led=%b time_out=%05h",
                         e.st, e.en, e.clr, e.led, e.t);
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        bus.btn_ss  = 1'b0;
        bus.btn_lr  = 1'b0;
        bus.time_in = 20'h00042;
        sb.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 20'h00042));
        repeat (3) step();
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset: got %s, expected %s", fmt(got), fmt(want));
        end
        rstn = 1'b1;
    endtask

    task automatic test_start();
        for (int c = 1; c <= 18; c++) begin
            bus.btn_ss = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_RUN : S_IDLE, c >= PRESS_AT, 1'b0, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL start c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_lap();
        bus.time_in = 20'h00123;
        for (int c = 1; c <= 18; c++) begin
            bus.btn_lr = (c <= 10);
            if (c > PRESS_AT) bus.time_in = bus.time_in + 20'd1;
            sb.push_back(mk(c >= PRESS_AT ? S_LAP : S_RUN, 1'b1, 1'b0, c >= PRESS_AT,
                            c >= PRESS_AT ? 20'h00123 : bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lap_enter c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        for (int c = 1; c <= 18; c++) begin
            bus.btn_lr  = (c <= 10);
            bus.time_in = bus.time_in + 20'd3;
            sb.push_back(mk(c >= PRESS_AT ? S_RUN : S_LAP, 1'b1, 1'b0, c < PRESS_AT,
                            c >= PRESS_AT ? bus.time_in : 20'h00123));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lap_exit c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.time_in = 20'hABCDE;
        for (int c = 1; c <= 18; c++) begin
            bus.btn_ss = (c <= 10);
            bus.btn_lr = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_STOP : S_RUN, c < PRESS_AT, 1'b0, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL simultaneous c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_clear();
        for (int c = 1; c <= 18; c++) begin
            bus.btn_lr = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_IDLE : S_STOP, 1'b0, c == PRESS_AT, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clear_stop c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        for (int c = 1; c <= 18; c++) begin
            bus.btn_lr = (c <= 10);
            sb.push_back(mk(S_IDLE, 1'b0, c == PRESS_AT, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clear_idle c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_glitch();
        for (int w = 1; w <= 3; w++) begin
            for (int c = 1; c <= w + DB + 6; c++) begin
                bus.btn_ss = (c <= w);
                sb.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, bus.time_in));
                step();
                got = sample(); want = sb.pop_front(); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL glitch w=%0d c=%0d: got %s, expected %s", w, c, fmt(got), fmt(want));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.time_in = 20'h55555;
        for (int c = 1; c <= 18; c++) begin
            bus.btn_ss = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_RUN : S_IDLE, c >= PRESS_AT, 1'b0, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arst_run c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        for (int c = 1; c <= 18; c++) begin
            bus.btn_lr = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_LAP : S_RUN, 1'b1, 1'b0, c >= PRESS_AT, 20'h55555));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arst_lap c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        // Start/stop debounce half done while in LAP, then reset mid-cycle.
        bus.time_in = 20'h11111;
        for (int c = 1; c <= 4; c++) begin
            bus.btn_ss = 1'b1;
            sb.push_back(mk(S_LAP, 1'b1, 1'b0, 1'b1, 20'h55555));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arst_half c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        #3;
        rstn = 1'b0;
        sb.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 20'h11111));
        #1;
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL arst_immediate: got %s, expected %s", fmt(got), fmt(want));
        end
        bus.btn_ss = 1'b0;
        step();
        step();
        rstn = 1'b1;
        for (int c = 1; c <= DB + 6; c++) begin
            sb.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arst_quiet c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
        // Button held through reset release is a fresh press.
        bus.btn_ss = 1'b1;
        rstn       = 1'b0;
        step();
        step();
        rstn = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            bus.btn_ss = (c <= 10);
            sb.push_back(mk(c >= PRESS_AT ? S_RUN : S_IDLE, c >= PRESS_AT, 1'b0, 1'b0, bus.time_in));
            step();
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL arst_held c=%0d: got %s, expected %s", c, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_simultaneous();
        test_clear();
        test_glitch();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, meaning the debounce stability window in clk_sys cycles (20 ms at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter TW, default 20, meaning the width of the time bus.
REQ-003 Port clk_sys  input  1  system clock; all state is updated on its rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port btn_ss  input  1  raw start/stop pushbutton, active-high, asynchronous to clk_sys.
REQ-006 Port btn_lr  input  1  raw lap/reset pushbutton, active-high, asynchronous to clk_sys.
REQ-007 Port time_in  input  TW  live time value from the counter datapath.
REQ-008 Port cnt_en  output  1  counter run enable, registered.
REQ-009 Port cnt_clr  output  1  counter synchronous clear, one-cycle pulse, registered.
REQ-010 Port time_out  output  TW  value forwarded to the display driver.
REQ-011 Port state  output  2  current FSM state: IDLE=0, RUN=1, LAP=2, STOP=3.
REQ-012 Port lap_led  output  1  high while state is LAP.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Per-button debounce: a counter SHALL increment each cycle while s2 differs from the stable level.
REQ-015 The debounce counter SHALL clear on any cycle where s2 equals the stable level.
REQ-016 When s2 has differed from the stable level for DB_CYCLES consecutive cycles, the stable level SHALL take the value of s2 and the counter SHALL clear.
REQ-017 A glitch shorter than DB_CYCLES cycles SHALL NOT change the stable level.
REQ-018 A press SHALL be the 0->1 transition of the stable level; release (1->0) SHALL produce no event.
REQ-019 The FSM transition for a press SHALL occur exactly DB_CYCLES+3 clk_sys edges after the raw input is first sampled high and held.
REQ-020 IDLE: on an ss press, go to RUN; on an lr press, pulse cnt_clr and stay in IDLE.
REQ-021 RUN: on an ss press, go to STOP; on an lr press, go to LAP and capture time_in into the snapshot register on the same edge.
REQ-022 LAP: on an ss press, go to STOP and release the display; on an lr press, return to RUN and release the display.
REQ-023 STOP: on an ss press, go to RUN; on an lr press, pulse cnt_clr and go to IDLE.
REQ-024 Simultaneous ss and lr press events in the same cycle: ss SHALL win and the lr event SHALL be discarded.
REQ-025 cnt_en SHALL be 1 exactly when the registered state is RUN or LAP.
REQ-026 cnt_en SHALL change in the same cycle as the state change.
REQ-027 cnt_clr SHALL be high for exactly one cycle, in the cycle following the edge that accepted the lr press in IDLE or STOP.
REQ-028 cnt_clr SHALL never be high while cnt_en is high.
REQ-029 time_out SHALL equal the snapshot register while in LAP; otherwise time_out SHALL equal time_in combinationally with zero latency.
REQ-030 The snapshot register SHALL hold its value outside LAP and SHALL load only on the RUN->LAP transition.
REQ-031 No arithmetic is performed on time_in; the width is TW throughout with no truncation.

Reset
REQ-032 While rstn=0: state=IDLE, cnt_en=0, cnt_clr=0, lap_led=0, snapshot=0, synchronizers=0, stable levels=0, debounce counters=0.
REQ-033 An assertion of rstn mid-operation (any state, mid-debounce) SHALL force all REQ-032 values immediately, without waiting for a clock edge.
REQ-034 A button held through reset deassertion SHALL be treated as a new press, accepted DB_CYCLES+3 edges after release of reset.

Verification (DB_CYCLES=4 for simulation)
REQ-035 Reset, press ss and hold 10 cycles -> state goes 0->1 at edge 7 after first high sample; cnt_en=1 from the same cycle.
REQ-036 In RUN with time_in=0x00123, press lr, then ramp time_in -> state=2, lap_led=1, time_out stays 0x00123; second lr press -> state=1, time_out tracks time_in.
REQ-037 ss pulses of 1, 2 and 3 cycles in IDLE -> no state change, cnt_en stays 0.
REQ-038 In STOP, press lr -> cnt_clr high exactly 1 cycle, state=0, cnt_en=0 throughout.
REQ-039 ss and lr raised on the same cycle in RUN -> state=3 (STOP), no LAP entry, snapshot unchanged.
REQ-040 In LAP with a debounce half complete, drive rstn=0 asynchronously -> outputs reach reset values before the next edge; after release, no spurious press unless the button is still held.
